// File: rtl/reload_down_counter.sv
// Loadable down-counter / interval timer with handshake load, terminal pulse and optional auto-reload.
// Define RDC_PRELOAD_EN to allow loads to be accepted while the counter is running.
module reload_down_counter #(
    parameter int WIDTH = 8,
    parameter int TCW   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             stop,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_value,
    output logic             load_ready,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count_out,
    output logic             tc_pulse,
    output logic             done,
    output logic             busy,
    output logic [TCW-1:0]   tc_count
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [TCW-1:0] TC_MAX = '1;

`ifdef RDC_PRELOAD_EN
    localparam logic RUN_READY = 1'b1;
`else
    localparam logic RUN_READY = 1'b0;
`endif

    state_t           state, state_next;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    logic             tc_pulse_next;
    logic [TCW-1:0]   tc_count_next;
    logic             accept;
    logic             terminal;

    assign load_ready = !stop && ((state != RUN) || RUN_READY);
    assign accept     = load_valid && load_ready;
    assign terminal   = (state == RUN) && enable && (count_out == '0);
    assign busy       = (state == RUN);
    assign done       = (state == DONE);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
        state_next    = state;
        count_next    = count_out;
        reload_next   = reload_reg;
        tc_pulse_next = 1'b0;
        tc_count_next = tc_count;

        if (stop) begin
            state_next    = IDLE;
            count_next    = '0;
            tc_count_next = '0;
        end else begin
            if (terminal) begin
                tc_pulse_next = 1'b1;
                if (tc_count != TC_MAX)
                    tc_count_next = tc_count + 1'b1;
            end

            // A load accepted on a terminal edge wins over the reload/stop decision.
            if (accept) begin
                count_next  = load_value;
                reload_next = load_value;
                state_next  = RUN;
            end else if ((state == RUN) && enable) begin
                if (count_out != '0)
                    count_next = count_out - 1'b1;
                else if (auto_reload)
                    count_next = reload_reg;
                else
                    state_next = DONE;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count_out  <= '0;
            reload_reg <= '0;
            tc_pulse   <= 1'b0;
            tc_count   <= '0;
        end else begin
            state      <= state_next;
            count_out  <= count_next;
            reload_reg <= reload_next;
            tc_pulse   <= tc_pulse_next;
            tc_count   <= tc_count_next;
        end
    end

endmodule

// File: doc/reload_down_counter.md
# reload_down_counter

Loadable, parameterised down-counter and interval timer. It is the counterpart to the team's free-running up-counter. A value is loaded through a valid/ready handshake and decremented on each enabled cycle. On a terminal event the block pulses a flag and then either stops or reloads itself. It sits beside the up-counter in the core's timing and test fabric and drives timeouts and periodic ticks.

## Interface
Parameters:
- WIDTH, 8, count and load width (≥ 2)
- TCW, 8, width of the saturating terminal-event counter

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- enable  in  1  count enable; low freezes the count and all state
- stop  in  1  synchronous abort to IDLE
- load_valid  in  1  load request
- load_value  in  WIDTH  value to load
- load_ready  out  1  load can be accepted this cycle
- auto_reload  in  1  at a terminal event, reload instead of stopping
- count_out  out  WIDTH  current count
- tc_pulse  out  1  one-cycle terminal-event flag (registered)
- done  out  1  level; the counter expired without reload
- busy  out  1  level; state is RUN
- tc_count  out  TCW  saturating count of terminal events

## Operation
- States: IDLE, RUN, DONE. busy = (RUN); done = (DONE).
- Load acceptance:
  - A load is accepted when load_valid && load_ready at a rising edge.
  - On acceptance, count_out and the internal reload register take load_value, and the state goes to RUN.
  - Acceptance does not depend on enable.
- load_ready:
  - 1 in IDLE and DONE.
  - In RUN it is set by configuration (see below).
  - Always 0 in a cycle where stop = 1.
- RUN, enabled edge with count_out ≠ 0: count_out ← count_out − 1.
- RUN, enabled edge with count_out = 0 (terminal event):
  - tc_pulse ← 1.
  - tc_count ← tc_count + 1, saturating at 2^TCW − 1.
  - If auto_reload = 1 (sampled at that edge): count_out ← reload register and the state stays RUN.
  - Otherwise the state goes to DONE and count_out stays 0.
- Period: a loaded value N gives one terminal event every N+1 enabled cycles. Loading 0 gives a terminal event on every enabled cycle.
- enable = 0 in RUN: count_out, state and tc_count hold, and tc_pulse is 0.
- stop = 1 at an edge:
  - State goes to IDLE; count_out, tc_count and tc_pulse are cleared to 0.
  - stop overrides load, terminal event and enable.
- IDLE and DONE ignore enable. count_out holds its value: 0 in both.
- tc_count is cleared only by reset or stop. A new load does not clear it.

## Timing
- Reset values: count_out = 0, tc_pulse = 0, done = 0, busy = 0, tc_count = 0, load_ready = 1, state IDLE. Reset is asynchronous and takes effect mid-operation without waiting for clk.
- A load accepted at edge k makes count_out = load_value after edge k. The first decrement happens at the next enabled edge after k.
- tc_pulse is high for exactly the one cycle after the terminal edge. With auto-reload it can be high on consecutive cycles only when the reload value is 0.
- done rises in the cycle after the terminal edge and falls after the next accepted load or stop.
- Wrap-around: count_out never decrements below 0. Reload from the register takes no extra cycle.

## Configuration
- RDC_PRELOAD_EN defined:
  - load_ready = 1 in RUN as well (except when stop = 1).
  - A load accepted in RUN restarts the count from load_value and replaces the reload register.
  - If the same edge is also a terminal event, the load wins: no reload takes place, but tc_pulse and tc_count still register the event.
- RDC_PRELOAD_EN undefined:
  - load_ready = 0 in RUN.
  - Loads are accepted only in IDLE or DONE.

## Test plan
- Reset mid-count: load 5, run 2 enabled cycles, assert reset between edges → all outputs return to reset values immediately.
- One-shot: load 3 with enable = 1 and auto_reload = 0 → count_out 3, 2, 1, 0, then tc_pulse for one cycle after the 4th enabled edge. Expect done = 1, busy = 0, tc_count = 1.
- Auto-reload: load 2 with auto_reload = 1 for 9 enabled cycles → tc_pulse every 3rd cycle, tc_count = 3, busy stays 1.
- Enable gating and stop:
  - Load 4 and toggle enable 1, 0, 1 → count_out 4, 3, 3, 2.
  - Assert stop together with load_valid → IDLE, count_out = 0, load not accepted.
- Saturation: TCW = 2, load 0 with auto_reload = 1 for 6 enabled cycles → tc_pulse every cycle, tc_count sticks at 3.
- Preload:
  - With RDC_PRELOAD_EN: load 7, then in RUN load 1 → count_out = 1 next cycle.
  - Without the macro: load_ready = 0 in RUN and count_out continues from 7.
